rxm_avl_slave_model: RTL

- Parametrised successor to the fixed six-channel Rxm stub in the tlp layer.
- Terminates NUM_CH Avalon-MM Rxm master channels from tlp_rx_cntrl (one per BAR) on a shared word-addressed memory.
- Round-robin arbitration between channels; burst writes with byte enables; burst reads with pipelined read-data return; programmable waitrequest stalls.
- Used in system simulation and as a loopback target for BAR traffic.

---
 rtl/rxm_avl_slave_model.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/rxm_avl_slave_model.sv
// Shared-memory Avalon-MM slave terminating NUM_CH Rxm master channels.
// Round-robin arbitration, byte-enabled burst writes, pipelined burst reads.
module rxm_avl_slave_model #(
    parameter int NUM_CH            = 6,
    parameter int AVALON_ADDR_WIDTH = 32,
    parameter int CB_RXM_DATA_WIDTH = 64,
    parameter int MEM_DEPTH         = 256,
    parameter int WAIT_CYCLES       = 0
) (
    input  logic                                  Clk_i,
    input  logic                                  Rstn_i,
    input  logic [NUM_CH-1:0]                     RxmWrite_o,
    input  logic [NUM_CH-1:0]                     RxmRead_o,
    input  logic [NUM_CH*AVALON_ADDR_WIDTH-1:0]   RxmAddress_o,
    input  logic [NUM_CH*CB_RXM_DATA_WIDTH-1:0]   RxmWriteData_o,
    input  logic [NUM_CH*CB_RXM_DATA_WIDTH/8-1:0] RxmByteEnable_o,
    input  logic [NUM_CH*7-1:0]                   RxmBurstCount_o,
    output logic [NUM_CH-1:0]                     RxmWaitRequest_i,
    output logic [CB_RXM_DATA_WIDTH-1:0]          RxmReadData_i,
    output logic [NUM_CH-1:0]                     RxmReadDataValid_i,
    output logic [31:0]                           BeatCnt,
    output logic                                  ProtoErr
);
    localparam int AW  = AVALON_ADDR_WIDTH;
    localparam int DW  = CB_RXM_DATA_WIDTH;
    localparam int BEW = DW / 8;
    localparam int BW  = $clog2(BEW);
    localparam int IW  = $clog2(MEM_DEPTH);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {IDLE, STALL, WR, RD_CMD, RD_DATA} state_t;
    state_t state, stateNxt;

    logic [DW-1:0]     mem [MEM_DEPTH];
    logic [DW-1:0]     memQ;
    logic              memQv;
    logic [CHW-1:0]    rrPtr, gnt, reqSel, nextPtr;
    logic [CHW:0]      sum;
    logic [NUM_CH-1:0] reqVec;
    logic              reqHit;
    logic [IW-1:0]     baseIdx, memIdx;
    logic [6:0]        burstLen, beat, retCnt;
    logic              isWrite;
    logic [3:0]        stallCnt;
    logic              wrBeat, wrLast, rdLast;

    logic [AW-1:0]     selAddr;
    logic [6:0]        selBurst;
    logic              selWrite, selRead, gWrite, gRead;
    logic [DW-1:0]     gWdata;
    logic [BEW-1:0]    gBe;
    logic              unusedAddr;

    // Cyclic search starting at the round-robin pointer.
    always_comb begin
        reqVec = RxmWrite_o | RxmRead_o;
        reqHit = 1'b0;
        reqSel = '0;
        sum    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, rrPtr} + (CHW+1)'(i);
            if (sum >= (CHW+1)'(NUM_CH))
                sum = sum - (CHW+1)'(NUM_CH);
            if (!reqHit && reqVec[sum[CHW-1:0]]) begin
                reqHit = 1'b1;
                reqSel = sum[CHW-1:0];
            end
        end
    end

    always_comb begin
        selAddr  = '0;
        selBurst = '0;
        selWrite = 1'b0;
        selRead  = 1'b0;
        gWrite   = 1'b0;
        gRead    = 1'b0;
        gWdata   = '0;
        gBe      = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (reqSel == CHW'(c)) begin
                selAddr  = RxmAddress_o[c*AW +: AW];
                selBurst = RxmBurstCount_o[c*7 +: 7];
                selWrite = RxmWrite_o[c];
                selRead  = RxmRead_o[c];
            end
            if (gnt == CHW'(c)) begin
                gWrite = RxmWrite_o[c];
                gRead  = RxmRead_o[c];
                gWdata = RxmWriteData_o[c*DW +: DW];
                gBe    = RxmByteEnable_o[c*BEW +: BEW];
            end
        end
    end

    // Only the word-index slice of the byte address is decoded.
    assign unusedAddr = &{1'b0, selAddr};

    assign memIdx  = baseIdx + IW'(beat);
    assign nextPtr = (gnt == CHW'(NUM_CH - 1)) ? '0 : gnt + CHW'(1);
    assign wrLast  = (beat == burstLen - 7'd1);
    assign rdLast  = memQv && (retCnt == burstLen - 7'd1);

    always_ff @(posedge Clk_i or negedge Rstn_i) begin
        if (!Rstn_i)
            state <= IDLE;
        else
            state <= stateNxt;
    end

    always_comb begin
        stateNxt         = state;
        RxmWaitRequest_i = '1;
        wrBeat           = 1'b0;
        case (state)
            IDLE: begin
                if (reqHit)
                    stateNxt = (WAIT_CYCLES > 0) ? STALL : (selWrite ? WR : RD_CMD);
            end
            STALL: begin
                if (stallCnt == 4'(WAIT_CYCLES - 1))
                    stateNxt = isWrite ? WR : RD_CMD;
            end
            WR: begin
                RxmWaitRequest_i[gnt] = 1'b0;
                wrBeat = gWrite;
                if (gWrite && wrLast)
                    stateNxt = IDLE;
            end
            RD_CMD: begin
                RxmWaitRequest_i[gnt] = 1'b0;
                if (gRead)
                    stateNxt = RD_DATA;
            end
            RD_DATA: begin
                if (rdLast)
                    stateNxt = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Rstn_i) begin
        if (!Rstn_i) begin
            rrPtr              <= '0;
            gnt                <= '0;
            baseIdx            <= '0;
            burstLen           <= 7'd1;
            beat               <= '0;
            retCnt             <= '0;
            isWrite            <= 1'b0;
            stallCnt           <= '0;
            memQv              <= 1'b0;
            RxmReadData_i      <= '0;
            RxmReadDataValid_i <= '0;
            BeatCnt            <= '0;
            ProtoErr           <= 1'b0;
        end else begin
            RxmReadDataValid_i <= '0;
            memQv              <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqHit) begin
                        gnt      <= reqSel;
                        baseIdx  <= selAddr[BW +: IW];
                        isWrite  <= selWrite;
                        burstLen <= (selBurst == 7'd0) ? 7'd1 : selBurst;
                        beat     <= '0;
                        retCnt   <= '0;
                        stallCnt <= '0;
                        if ((selWrite && selRead) || selBurst == 7'd0)
                            ProtoErr <= 1'b1;
                    end
                end
                STALL: stallCnt <= stallCnt + 4'd1;
                WR: begin
                    if (wrBeat) begin
                        beat    <= beat + 7'd1;
                        BeatCnt <= BeatCnt + 32'd1;
                        if (wrLast)
                            rrPtr <= nextPtr;
                    end
                end
                RD_DATA: begin
                    // memQ captures mem[base+beat] on the same edge memQv rises
                    if (beat != burstLen) begin
                        memQv <= 1'b1;
                        beat  <= beat + 7'd1;
                    end
                    if (memQv) begin
                        RxmReadData_i           <= memQ;
                        RxmReadDataValid_i[gnt] <= 1'b1;
                        BeatCnt                 <= BeatCnt + 32'd1;
                        retCnt                  <= retCnt + 7'd1;
                        if (rdLast)
                            rrPtr <= nextPtr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk_i) begin
        if (wrBeat) begin
            for (int unsigned b = 0; b < BEW; b++)
                if (gBe[b])
                    mem[memIdx][b*8 +: 8] <= gWdata[b*8 +: 8];
        end
        memQ <= mem[memIdx];
    end

endmodule
